// File: rtl/snoop_agent.sv
// Bus-side agent of a snooping cache. It runs its own miss, upgrade and writeback
// transactions through a small FSM and answers peer broadcasts from a 16-entry line directory.
module snoop_agent #(
  parameter bit HIGH_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic [2:0]   req_cmd,
  input  logic [255:0] req_wdata,
  output logic         resp_valid,
  output logic         resp_hit,
  output logic [255:0] resp_rdata,
  output logic         bus_query,
  input  logic         peer_query,
  input  logic         bus_ready,
  output logic [31:0]  out_addr,
  output logic [2:0]   out_cmd,
  output logic [255:0] out_data,
  input  logic [1:0]   bus_resp,
  input  logic [255:0] bus_resp_data,
  input  logic [31:0]  snp_addr,
  input  logic [2:0]   snp_cmd,
  output logic [3:0]   snp_index,
  input  logic [255:0] snp_line,
  output logic         snp_hit,
  output logic [255:0] snp_data
);
  localparam int unsigned SETS = 16;
  localparam int unsigned SW   = 4;
  localparam int unsigned TW   = 23;
  localparam int unsigned DW   = 256;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_RDX  = 3'd2;
  localparam logic [2:0] CMD_UPGR = 3'd3;
  localparam logic [2:0] CMD_WB   = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_CMD, ST_RESP, ST_DONE} fsm_t;
  typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

  function automatic logic is_cmd(input logic [2:0] c);
    return (c != CMD_NONE) && (c <= CMD_WB);
  endfunction

  fsm_t            state, state_nxt;
  line_t           dir_st  [SETS];
  logic [TW-1:0]   dir_tag [SETS];
  logic            resp_hit_q;
  logic [DW-1:0]   resp_data_q;
  logic            snp_prev;
  logic            snp_start, snp_lookup_hit, snp_inval, upgr_lost, grant;
  line_t           snp_cur_st, snp_new_st;
  logic [SW-1:0]   snp_set, own_set;
  logic [TW-1:0]   snp_tag, own_tag;
  logic            unused_snp_off;

  assign unused_snp_off = ^snp_addr[4:0];
  assign grant     = bus_ready && (HIGH_PRIO || !peer_query);
  assign snp_set   = snp_addr[8:5];
  assign snp_tag   = snp_addr[31:9];
  assign own_set   = out_addr[8:5];
  assign own_tag   = out_addr[31:9];
  assign snp_index = snp_set;

  // A broadcast acts once, on its first cycle; our own bus phases are not snooped.
  assign snp_start = is_cmd(snp_cmd) && !snp_prev && (state != ST_CMD) && (state != ST_RESP);
  assign snp_lookup_hit = (dir_st[snp_set] != LN_I) && (dir_tag[snp_set] == snp_tag);
  assign snp_inval = snp_start && snp_lookup_hit && (snp_new_st == LN_I);
  // A pending upgrade whose shared copy is stolen must refetch the whole line.
  assign upgr_lost = (state == ST_REQ) && (out_cmd == CMD_UPGR) && snp_inval &&
                     (snp_addr[31:5] == out_addr[31:5]);

  always_comb begin
    snp_cur_st = dir_st[snp_set];
    snp_new_st = snp_cur_st;
    case (snp_cmd)
      CMD_RD:   if (snp_cur_st == LN_M) snp_new_st = LN_S;
      CMD_RDX:  snp_new_st = LN_I;
      CMD_UPGR: if (snp_cur_st == LN_S) snp_new_st = LN_I;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid && is_cmd(req_cmd)) state_nxt = ST_REQ;
      ST_REQ:  if (grant) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    bus_query  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_rdata = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ:  bus_query = 1'b1;
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_hit   = resp_hit_q;
        resp_rdata = resp_data_q;
      end
      default: ;
    endcase
  end

  // Own command registers: loaded on acceptance, held through the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr    <= '0;
      out_cmd     <= CMD_NONE;
      out_data    <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (state == ST_IDLE && req_valid && is_cmd(req_cmd)) begin
        out_addr <= req_addr;
        out_cmd  <= req_cmd;
        out_data <= req_wdata;
      end else if (state == ST_DONE) begin
        out_addr <= '0;
        out_cmd  <= CMD_NONE;
        out_data <= '0;
      end else if (upgr_lost) begin
        out_cmd <= CMD_RDX;
      end
      if (state == ST_RESP) begin
        resp_hit_q  <= (bus_resp == 2'd1);
        resp_data_q <= bus_resp_data;
      end
    end
  end

  // Snoop response registers, visible only in the cycle after the snoop starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      snp_prev <= 1'b0;
      snp_hit  <= 1'b0;
      snp_data <= '0;
    end else begin
      snp_prev <= is_cmd(snp_cmd);
      snp_hit  <= snp_start && snp_lookup_hit;
      snp_data <= snp_start ? snp_line : '0;
    end
  end

  // Directory: the completion write is last so it wins a same-set collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        dir_st[SW'(i)]  <= LN_I;
        dir_tag[SW'(i)] <= '0;
      end
    end else begin
      if (snp_start && snp_lookup_hit) dir_st[snp_set] <= snp_new_st;
      if (state == ST_DONE) begin
        case (out_cmd)
          CMD_RD: begin
            dir_tag[own_set] <= own_tag;
            dir_st[own_set]  <= LN_S;
          end
          CMD_RDX, CMD_UPGR: begin
            dir_tag[own_set] <= own_tag;
            dir_st[own_set]  <= LN_M;
          end
          CMD_WB:  dir_st[own_set] <= LN_I;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_snoop_agent.sv
// Directed bench for snoop_agent: table of own/snoop operations plus multi-cycle corner sequences.
module tb_snoop_agent;
  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_RD   = 3'd1;
  localparam logic [2:0] C_RDX  = 3'd2;
  localparam logic [2:0] C_UPGR = 3'd3;
  localparam logic [2:0] C_WB   = 3'd4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic [2:0]   req_cmd;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_hit;
  logic [255:0] resp_rdata;
  logic         bus_query, peer_query, bus_ready;
  logic [31:0]  out_addr;
  logic [2:0]   out_cmd;
  logic [255:0] out_data;
  logic [1:0]   bus_resp;
  logic [255:0] bus_resp_data;
  logic [31:0]  snp_addr;
  logic [2:0]   snp_cmd;
  logic [3:0]   snp_index;
  logic [255:0] snp_line;
  logic         snp_hit;
  logic [255:0] snp_data;

  always #5 clk = ~clk;

  snoop_agent #(.HIGH_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_cmd(req_cmd), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .bus_query(bus_query), .peer_query(peer_query), .bus_ready(bus_ready),
    .out_addr(out_addr), .out_cmd(out_cmd), .out_data(out_data),
    .bus_resp(bus_resp), .bus_resp_data(bus_resp_data),
    .snp_addr(snp_addr), .snp_cmd(snp_cmd), .snp_index(snp_index),
    .snp_line(snp_line), .snp_hit(snp_hit), .snp_data(snp_data)
  );

  typedef struct {
    bit          own;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  bresp;
    bit          exp_hit;
    bit          acc;
  } vec_t;

  vec_t vecs [24];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic start_req(input logic [2:0] cmd, input logic [31:0] addr,
                           input logic [255:0] wd, input logic peer);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
    peer_query = peer; bus_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_cmd = C_NONE;
  endtask

  // Called in the grant cycle (REQ, bus free, peer idle); runs to the return to IDLE.
  task automatic finish_txn(input logic [1:0] bresp, input bit exp_hit, input string t);
    logic [255:0] rd;
    rd = rnd256();
    tick();
    check({t, "_cmd_query"}, 256'(bus_query), 256'(0));
    check({t, "_cmd_valid"}, 256'(resp_valid), 256'(0));
    tick();
    check({t, "_resp_valid"}, 256'(resp_valid), 256'(0));
    bus_resp = bresp; bus_resp_data = rd;
    tick();
    bus_resp = 2'd0; bus_resp_data = '0;
    check({t, "_done_valid"}, 256'(resp_valid), 256'(1));
    check({t, "_done_hit"}, 256'(resp_hit), 256'(exp_hit));
    check({t, "_done_rdata"}, resp_rdata, rd);
    tick();
    check({t, "_idle_valid"}, 256'(resp_valid), 256'(0));
    check({t, "_idle_outcmd"}, 256'(out_cmd), 256'(0));
    check({t, "_idle_outaddr"}, 256'(out_addr), 256'(0));
    check({t, "_idle_ready"}, 256'(req_ready), 256'(1));
  endtask

  task automatic own_txn(input logic [2:0] cmd, input logic [31:0] addr, input logic [1:0] bresp,
                         input bit exp_hit, input bit acc, input string t);
    logic [255:0] wd;
    wd = rnd256();
    check({t, "_ready"}, 256'(req_ready), 256'(1));
    start_req(cmd, addr, wd, 1'b0);
    if (!acc) begin
      check({t, "_nacc_query"}, 256'(bus_query), 256'(0));
      check({t, "_nacc_outcmd"}, 256'(out_cmd), 256'(0));
      check({t, "_nacc_ready"}, 256'(req_ready), 256'(1));
    end else begin
      check({t, "_req_query"}, 256'(bus_query), 256'(1));
      check({t, "_req_outaddr"}, 256'(out_addr), 256'(addr));
      check({t, "_req_outcmd"}, 256'(out_cmd), 256'(cmd));
      check({t, "_req_outdata"}, out_data, wd);
      check({t, "_req_ready"}, 256'(req_ready), 256'(0));
      finish_txn(bresp, exp_hit, t);
    end
  endtask

  task automatic snoop(input logic [2:0] cmd, input logic [31:0] addr, input bit exp_hit,
                       input string t);
    logic [255:0] ln;
    ln = rnd256();
    snp_cmd = cmd; snp_addr = addr; snp_line = ln;
    check({t, "_snp_index"}, 256'(snp_index), 256'(addr[8:5]));
    tick();
    snp_cmd = C_NONE;
    check({t, "_snp_hit"}, 256'(snp_hit), 256'(exp_hit));
    if (exp_hit) check({t, "_snp_data"}, snp_data, ln);
    tick();
    check({t, "_snp_hit_clr"}, 256'(snp_hit), 256'(0));
    check({t, "_snp_data_clr"}, snp_data, 256'(0));
  endtask

  initial begin
    logic [255:0] wd, rd;
    bit saw;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_cmd = C_NONE; req_wdata = '0;
    peer_query = 1'b0; bus_ready = 1'b1; bus_resp = 2'd0; bus_resp_data = '0;
    snp_addr = '0; snp_cmd = C_NONE; snp_line = '0;
    tick(); tick();
    check("rst_ready", 256'(req_ready), 256'(1));
    check("rst_query", 256'(bus_query), 256'(0));
    check("rst_valid", 256'(resp_valid), 256'(0));
    check("rst_snphit", 256'(snp_hit), 256'(0));
    check("rst_outaddr", 256'(out_addr), 256'(0));
    check("rst_outcmd", 256'(out_cmd), 256'(0));
    check("rst_outdata", out_data, 256'(0));
    check("rst_rdata", resp_rdata, 256'(0));
    check("rst_snpdata", snp_data, 256'(0));
    rst = 1'b0;
    tick();

    vecs[0]  = '{1'b0, C_RD,   32'h0000_0120, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, C_RD,   32'h0000_0120, 2'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, C_RD,   32'h0000_0120, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, C_UPGR, 32'h0000_0120, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, C_RD,   32'h0000_0120, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, C_RDX,  32'h0000_0120, 2'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, C_RD,   32'h0000_0120, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, C_UPGR, 32'h0000_0120, 2'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, C_RDX,  32'h0000_0120, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, C_RD,   32'h0000_0060, 2'd2, 1'b0, 1'b1};
    vecs[10] = '{1'b0, C_RD,   32'h0000_0260, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, C_RD,   32'h0000_0060, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, C_WB,   32'h0000_0060, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, C_RD,   32'h0000_0060, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, C_WB,   32'h0000_0060, 2'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, C_RDX,  32'h0000_0060, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, C_NONE, 32'h0000_0200, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 3'd5,   32'h0000_0200, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, C_UPGR, 32'hFFFF_FFE0, 2'd0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 3'd6,   32'hFFFF_FFE0, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, C_RD,   32'hFFFF_FFE0, 2'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, C_UPGR, 32'hFFFF_FFE0, 2'd0, 1'b1, 1'b0};
    vecs[22] = '{1'b0, C_RDX,  32'hFFFF_FFE0, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, C_RD,   32'h0000_01A0, 2'd3, 1'b0, 1'b1};

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].own)
        own_txn(vecs[i].cmd, vecs[i].addr, vecs[i].bresp, vecs[i].exp_hit, vecs[i].acc,
                $sformatf("v%0d", i));
      else
        snoop(vecs[i].cmd, vecs[i].addr, vecs[i].exp_hit, $sformatf("v%0d", i));
    end

    // Peer contention and busy bus: request held with stable command until free.
    wd = rnd256();
    start_req(C_RD, 32'h0000_0300, wd, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("a_hold%0d_query", k), 256'(bus_query), 256'(1));
      check($sformatf("a_hold%0d_outaddr", k), 256'(out_addr), 256'(32'h300));
      check($sformatf("a_hold%0d_outcmd", k), 256'(out_cmd), 256'(C_RD));
      check($sformatf("a_hold%0d_outdata", k), out_data, wd);
      tick();
    end
    peer_query = 1'b0; bus_ready = 1'b0;
    tick();
    check("a_busy_query", 256'(bus_query), 256'(1));
    bus_ready = 1'b1;
    finish_txn(2'd2, 1'b0, "a");

    // Pending upgrade loses its shared copy to a peer RDX and becomes a full read.
    own_txn(C_RD, 32'h0000_0120, 2'd2, 1'b0, 1'b1, "b_rd");
    wd = rnd256();
    start_req(C_UPGR, 32'h0000_0120, wd, 1'b1);
    check("b_outcmd_upgr", 256'(out_cmd), 256'(C_UPGR));
    snp_cmd = C_RDX; snp_addr = 32'h0000_0120; snp_line = rnd256();
    tick();
    snp_cmd = C_NONE;
    check("b_snp_hit", 256'(snp_hit), 256'(1));
    check("b_outcmd_rdx", 256'(out_cmd), 256'(C_RDX));
    check("b_query", 256'(bus_query), 256'(1));
    check("b_outdata", out_data, wd);
    tick();
    peer_query = 1'b0;
    finish_txn(2'd0, 1'b0, "b_upg");
    snoop(C_UPGR, 32'h0000_0120, 1'b1, "b_p1");
    snoop(C_RD, 32'h0000_0120, 1'b1, "b_p2");

    // Two-cycle broadcast on a modified line: one response, line drops to shared.
    own_txn(C_RDX, 32'h0000_0120, 2'd1, 1'b1, 1'b1, "c_rdx");
    rd = rnd256();
    snp_cmd = C_RD; snp_addr = 32'h0000_0120; snp_line = rd;
    tick();
    check("c_cyc2_hit", 256'(snp_hit), 256'(1));
    check("c_cyc2_data", snp_data, rd);
    tick();
    snp_cmd = C_NONE;
    check("c_cyc3_hit", 256'(snp_hit), 256'(0));
    check("c_cyc3_data", snp_data, 256'(0));
    tick();
    snoop(C_UPGR, 32'h0000_0120, 1'b1, "c_p1");
    snoop(C_RD, 32'h0000_0120, 1'b0, "c_p2");

    // Invalidating snoop in the completion cycle of the same set: completion wins.
    own_txn(C_RD, 32'h0000_0120, 2'd2, 1'b0, 1'b1, "e_rd");
    start_req(C_RDX, 32'h0000_0120, rnd256(), 1'b0);
    tick();
    tick();
    bus_resp = 2'd1; bus_resp_data = rnd256();
    tick();
    bus_resp = 2'd0;
    check("e_done_valid", 256'(resp_valid), 256'(1));
    snp_cmd = C_RDX; snp_addr = 32'h0000_0120; snp_line = rnd256();
    tick();
    snp_cmd = C_NONE;
    check("e_snp_hit", 256'(snp_hit), 256'(1));
    check("e_valid_clr", 256'(resp_valid), 256'(0));
    tick();
    snoop(C_UPGR, 32'h0000_0120, 1'b1, "e_p1");
    snoop(C_RD, 32'h0000_0120, 1'b1, "e_p2");

    // Reset in the command phase abandons the transaction and clears the directory.
    own_txn(C_RD, 32'h0000_0060, 2'd2, 1'b0, 1'b1, "d_rd");
    start_req(C_RD, 32'h0000_01A0, rnd256(), 1'b0);
    tick();
    check("d_cmd_query", 256'(bus_query), 256'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d_query", 256'(bus_query), 256'(0));
    check("d_valid", 256'(resp_valid), 256'(0));
    check("d_ready", 256'(req_ready), 256'(1));
    check("d_outcmd", 256'(out_cmd), 256'(0));
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (resp_valid) saw = 1'b1;
    end
    check("d_no_resp", 256'(saw), 256'(0));
    snoop(C_RD, 32'h0000_0060, 1'b0, "d_p1");
    snoop(C_RD, 32'h0000_0120, 1'b0, "d_p2");
    snoop(C_RD, 32'h0000_0300, 1'b0, "d_p3");
    snoop(C_RD, 32'h0000_01A0, 1'b0, "d_p4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
